// File: rtl/pci_master_initiator.sv
// PCI initiator: converts one local read/write request of 1-4 words into a PCI
// burst with IRDY/TRDY handshake, DEVSEL-timeout master abort and target STOP handling.
module pci_master_initiator #(
  parameter logic [3:0] READ_OP        = 4'b0110,
  parameter logic [3:0] WRITE_OP       = 4'b0111,
  parameter int         DEVSEL_TIMEOUT = 4
) (
  input  logic        clk_i,
  input  logic        rest_i,
  input  logic        req_i,
  input  logic        req_rw_i,
  input  logic [31:0] req_addr_i,
  input  logic [2:0]  req_len_i,
  input  logic [3:0]  req_be_i,
  input  logic        ld_en_i,
  input  logic [1:0]  ld_idx_i,
  input  logic [31:0] ld_data_i,
  output logic        rd_valid_o,
  output logic [1:0]  rd_idx_o,
  output logic [31:0] rd_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  status_o,
  output logic        frame_o,
  output logic        irdy_o,
  output logic [3:0]  cbe_o,
  inout  wire  [31:0] ad_io,
  input  logic        trdy_i,
  input  logic        devsel_i,
  input  logic        stop_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ABRT = 3'd3;
  localparam logic [2:0] S_END  = 3'd4;
  localparam logic [3:0] TMO_LAST = 4'(DEVSEL_TIMEOUT - 1);

  logic [31:0] wbuf_q [4];

  logic [2:0]  state_q, state_d;
  logic        rw_q, rw_d;
  logic [2:0]  len_q, len_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  tmo_q, tmo_d;
  logic        frame_q, frame_d;
  logic        irdy_q, irdy_d;
  logic [3:0]  cbe_q, cbe_d;
  logic [31:0] ad_q, ad_d;
  logic        ad_oe_q, ad_oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  status_q, status_d;
  logic        rd_valid_q, rd_valid_d;
  logic [1:0]  rd_idx_q, rd_idx_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        ovr_q, ovr_d;
  logic [1:0]  ovr_idx_q, ovr_idx_d;
  logic [31:0] ovr_word_q, ovr_word_d;

  logic        req_ok;
  logic        xfer;
  logic [2:0]  cnt_inc;
  logic [2:0]  cnt_nx;
  logic [1:0]  wr_sel;
  logic [31:0] wr_word;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^req_addr_i[1:0];
  assign req_ok  = req_i && (req_len_i != 3'd0) && (req_len_i <= 3'd4);
  assign xfer    = !irdy_q && !trdy_i && !devsel_i;
  assign cnt_inc = cnt_q + 3'd1;
  assign cnt_nx  = xfer ? cnt_inc : cnt_q;
  assign wr_sel  = (state_q == S_ADDR) ? 2'd0 : cnt_inc[1:0];
  // A load landing on the same edge as the request must not leak into that burst.
  assign wr_word = (ovr_q && (ovr_idx_q == wr_sel)) ? ovr_word_q : wbuf_q[wr_sel];
  assign ad_io   = ad_oe_q ? ad_q : 32'hzzzz_zzzz;

  always_ff @(posedge clk_i) begin
    if (ld_en_i && (state_q == S_IDLE)) begin
      wbuf_q[ld_idx_i] <= ld_data_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    len_d      = len_q;
    be_d       = be_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    frame_d    = frame_q;
    irdy_d     = irdy_q;
    cbe_d      = cbe_q;
    ad_d       = ad_q;
    ad_oe_d    = ad_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    status_d   = status_q;
    rd_valid_d = 1'b0;
    rd_idx_d   = rd_idx_q;
    rd_data_d  = rd_data_q;
    ovr_d      = ovr_q;
    ovr_idx_d  = ovr_idx_q;
    ovr_word_d = ovr_word_q;
    case (state_q)
      S_IDLE: begin
        if (req_ok) begin
          state_d    = S_ADDR;
          rw_d       = req_rw_i;
          len_d      = req_len_i;
          be_d       = req_be_i;
          cnt_d      = 3'd0;
          tmo_d      = 4'd0;
          status_d   = 2'b00;
          busy_d     = 1'b1;
          frame_d    = 1'b0;
          ad_d       = {req_addr_i[31:2], 2'b00};
          ad_oe_d    = 1'b1;
          cbe_d      = req_rw_i ? WRITE_OP : READ_OP;
          ovr_d      = ld_en_i;
          ovr_idx_d  = ld_idx_i;
          ovr_word_d = wbuf_q[ld_idx_i];
        end
      end
      S_ADDR: begin
        state_d = S_DATA;
        frame_d = (len_q == 3'd1);
        irdy_d  = 1'b0;
        cbe_d   = be_q;
        ad_d    = wr_word;
        ad_oe_d = rw_q;
      end
      S_DATA: begin
        cnt_d = cnt_nx;
        if (xfer && !rw_q) begin
          rd_valid_d = 1'b1;
          rd_idx_d   = cnt_q[1:0];
          rd_data_d  = ad_io;
        end
        if (xfer && (cnt_inc == len_q)) begin
          state_d  = S_END;
          status_d = 2'b00;
          frame_d  = 1'b1;
          irdy_d   = 1'b1;
          ad_oe_d  = 1'b0;
          cbe_d    = 4'hF;
        end else if (!stop_i || (devsel_i && (tmo_q == TMO_LAST))) begin
          status_d = !stop_i ? ((cnt_nx < len_q) ? 2'b10 : 2'b00) : 2'b01;
          frame_d  = 1'b1;
          // FRAME already released on the last phase: nothing left to abort.
          if (frame_q) begin
            state_d = S_END;
            irdy_d  = 1'b1;
            ad_oe_d = 1'b0;
            cbe_d   = 4'hF;
          end else begin
            state_d = S_ABRT;
          end
        end else begin
          if (devsel_i) begin
            tmo_d = tmo_q + 4'd1;
          end
          if (xfer) begin
            ad_d    = wr_word;
            frame_d = (cnt_inc == (len_q - 3'd1));
          end
        end
      end
      S_ABRT: begin
        state_d = S_END;
        frame_d = 1'b1;
        irdy_d  = 1'b1;
        ad_oe_d = 1'b0;
        cbe_d   = 4'hF;
      end
      S_END: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rest_i) begin
      state_q    <= S_IDLE;
      rw_q       <= 1'b0;
      len_q      <= 3'd0;
      be_q       <= 4'hF;
      cnt_q      <= 3'd0;
      tmo_q      <= 4'd0;
      frame_q    <= 1'b1;
      irdy_q     <= 1'b1;
      cbe_q      <= 4'hF;
      ad_q       <= 32'd0;
      ad_oe_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= 2'b00;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= 2'd0;
      rd_data_q  <= 32'd0;
      ovr_q      <= 1'b0;
      ovr_idx_q  <= 2'd0;
      ovr_word_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      len_q      <= len_d;
      be_q       <= be_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      frame_q    <= frame_d;
      irdy_q     <= irdy_d;
      cbe_q      <= cbe_d;
      ad_q       <= ad_d;
      ad_oe_q    <= ad_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      status_q   <= status_d;
      rd_valid_q <= rd_valid_d;
      rd_idx_q   <= rd_idx_d;
      rd_data_q  <= rd_data_d;
      ovr_q      <= ovr_d;
      ovr_idx_q  <= ovr_idx_d;
      ovr_word_q <= ovr_word_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_idx_o   = rd_idx_q;
  assign rd_data_o  = rd_data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign status_o   = status_q;
  assign frame_o    = frame_q;
  assign irdy_o     = irdy_q;
  assign cbe_o      = cbe_q;

endmodule

// File: tb/tb_pci_master_initiator.sv
// Bench for pci_master_initiator: a behavioural PCI target plus a transaction-level
// expectation of words moved, status, latency and handshake ordering.
module tb_pci_master_initiator;

  logic        clk = 1'b0;
  logic        rest, req, req_rw, ld_en;
  logic [31:0] req_addr, ld_data;
  logic [2:0]  req_len;
  logic [3:0]  req_be;
  logic [1:0]  ld_idx;
  logic        rd_valid, busy, done, frame, irdy;
  logic [1:0]  rd_idx, status;
  logic [31:0] rd_data;
  logic [3:0]  cbe;
  wire  [31:0] ad;
  logic        trdy = 1'b1, devsel = 1'b1, stop = 1'b1;
  logic        tgt_drive = 1'b0;
  logic [31:0] tgt_ad = 32'd0;

  assign ad = tgt_drive ? tgt_ad : 32'hzzzz_zzzz;

  pci_master_initiator dut (
    .clk_i(clk), .rest_i(rest), .req_i(req), .req_rw_i(req_rw), .req_addr_i(req_addr),
    .req_len_i(req_len), .req_be_i(req_be), .ld_en_i(ld_en), .ld_idx_i(ld_idx),
    .ld_data_i(ld_data), .rd_valid_o(rd_valid), .rd_idx_o(rd_idx), .rd_data_o(rd_data),
    .busy_o(busy), .done_o(done), .status_o(status), .frame_o(frame), .irdy_o(irdy),
    .cbe_o(cbe), .ad_io(ad), .trdy_i(trdy), .devsel_i(devsel), .stop_i(stop)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Plan for the behavioural target and expectation model.
  bit          plan_dev;
  int          plan_stop;
  bit          plan_stop_data;
  int          plan_wait [4];
  logic [31:0] rd_pat [4];
  bit          cur_rw;
  int          cur_len;
  logic [3:0]  exp_be;
  logic [31:0] wmodel [4];

  // Observations gathered by the target/monitor.
  logic [31:0] wr_seen [$];
  logic [31:0] rd_seen_d [$];
  logic [1:0]  rd_seen_i [$];
  logic [31:0] addr_seen;
  logic [3:0]  cmd_seen;
  int addr_cnt = 0, done_cnt = 0, frame_err = 0, be_err = 0, order_err = 0;

  bit  tact = 1'b0, tstop = 1'b0;
  int  tph = 0, twt = 0;
  logic p_frame = 1'b1, p_irdy = 1'b1, p_trdy = 1'b1, p_devsel = 1'b1, p_stop = 1'b1;
  logic [31:0] p_ad = 32'd0;
  logic [3:0]  p_cbe = 4'hF;
  bit rdy;

  // Target: at each negedge interpret what the previous posedge sampled, then drive.
  always @(negedge clk) begin
    if (!tact) begin
      if (!p_frame && p_irdy) begin
        tact = 1'b1; tph = 0; twt = 0; tstop = 1'b0;
        addr_seen = p_ad; cmd_seen = p_cbe; addr_cnt++;
      end
    end else begin
      if (!p_irdy && !p_trdy && !p_devsel) begin
        if (p_frame != (tph == cur_len - 1)) frame_err++;
        if (p_cbe != exp_be) be_err++;
        if (cur_rw) wr_seen.push_back(p_ad);
        tph++; twt = 0;
      end else if (!p_irdy) begin
        twt++;
      end
      if (!p_stop) tstop = 1'b1;
      if (p_frame && p_irdy) tact = 1'b0;
    end
    if (!p_irdy && irdy && !p_frame) order_err++;
    if (rd_valid) begin
      rd_seen_d.push_back(rd_data);
      rd_seen_i.push_back(rd_idx);
    end
    if (done) done_cnt++;

    if (tact && !tstop && !irdy && tph < 4) begin
      devsel = plan_dev ? 1'b0 : 1'b1;
      rdy = plan_dev && (twt >= plan_wait[tph]);
      if (rdy && tph == plan_stop) begin
        stop = 1'b0; trdy = plan_stop_data ? 1'b0 : 1'b1;
      end else begin
        stop = 1'b1; trdy = rdy ? 1'b0 : 1'b1;
      end
      tgt_drive = !cur_rw && plan_dev;
      tgt_ad = rd_pat[tph];
    end else begin
      devsel = 1'b1; trdy = 1'b1; stop = 1'b1; tgt_drive = 1'b0;
    end
    p_frame = frame; p_irdy = irdy; p_trdy = trdy; p_devsel = devsel;
    p_stop = stop; p_ad = ad; p_cbe = cbe;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    wr_seen.delete(); rd_seen_d.delete(); rd_seen_i.delete();
    addr_cnt = 0; done_cnt = 0; frame_err = 0; be_err = 0; order_err = 0;
  endtask

  task automatic load(input logic [1:0] i, input logic [31:0] d);
    ld_en = 1'b1; ld_idx = i; ld_data = d;
    step();
    ld_en = 1'b0;
    wmodel[i] = d;
  endtask

  // wmode: 0 zero-wait, 1 random waits, 2 TRDY held off 2 cycles on first phase.
  task automatic run_txn(input bit rw, input logic [31:0] addr, input int len,
                         input logic [3:0] be, input bit dev, input int stph,
                         input bit stdat, input int wmode, input bit extra, input bit ldsame);
    logic [31:0] expw [4];
    logic [1:0]  lj;
    logic [31:0] lnew;
    int nw, lat, n, exp_lat;
    logic [1:0] exp_st;
    plan_dev = dev; plan_stop = stph; plan_stop_data = stdat;
    for (int i = 0; i < 4; i++) begin
      plan_wait[i] = (wmode == 1) ? $urandom_range(0, 3) : 0;
      rd_pat[i] = $urandom;
      expw[i] = wmodel[i];
    end
    if (wmode == 2) plan_wait[0] = 2;
    cur_rw = rw; cur_len = len; exp_be = be;
    clear_obs();
    req = 1'b1; req_rw = rw; req_addr = addr; req_len = 3'(len); req_be = be;
    lj = 2'($urandom_range(0, 3)); lnew = $urandom;
    if (ldsame) begin
      ld_en = 1'b1; ld_idx = lj; ld_data = lnew;
    end
    step();
    req = 1'b0; ld_en = 1'b0;
    if (ldsame) wmodel[lj] = lnew;
    n = 0; lat = -1;
    while (lat < 0 && n < 80) begin
      step(); n++;
      req = 1'b0; ld_en = 1'b0;
      if (done) lat = n;
      else if (n == 2 && extra) begin
        req = 1'b1; req_len = 3'd1;
        ld_en = 1'b1; ld_idx = lj; ld_data = ~lnew;
      end
    end
    req = 1'b0; ld_en = 1'b0;
    repeat (3) step();

    if (!dev) nw = 0;
    else if (stph >= 0 && stph < len) nw = stph + (stdat ? 1 : 0);
    else nw = len;
    exp_st = !dev ? 2'b01 : ((nw < len) ? 2'b10 : 2'b00);

    check("done_seen", 32'(lat >= 0), 32'd1);
    check("done_once", done_cnt, 1);
    check("addr_phases", addr_cnt, 1);
    check("addr", addr_seen, {addr[31:2], 2'b00});
    check("cmd", {28'd0, cmd_seen}, rw ? 32'h7 : 32'h6);
    check("status", {30'd0, status}, {30'd0, exp_st});
    check("busy_after", {31'd0, busy}, 32'd0);
    check("frame_on_last", frame_err, 0);
    check("cbe_data", be_err, 0);
    check("frame_before_irdy", order_err, 0);
    if (rw) begin
      check("wr_words", wr_seen.size(), nw);
      check("rd_pulses_on_write", rd_seen_d.size(), 0);
      for (int i = 0; i < nw && i < wr_seen.size(); i++) check("wr_data", wr_seen[i], expw[i]);
    end else begin
      check("rd_words", rd_seen_d.size(), nw);
      for (int i = 0; i < nw && i < rd_seen_d.size(); i++) begin
        check("rd_data", rd_seen_d[i], rd_pat[i]);
        check("rd_idx", {30'd0, rd_seen_i[i]}, 32'(i));
      end
    end
    exp_lat = -1;
    if (!dev) exp_lat = 6 + ((len > 1) ? 1 : 0);
    else if (wmode == 0 && (stph < 0 || stph >= len)) exp_lat = len + 2;
    if (exp_lat >= 0) check("latency", lat, exp_lat);
    $display("[TB] txn rw=%0d addr=%h len=%0d dev=%0d stop=%0d status=%0d words=%0d lat=%0d",
             rw, addr, len, dev, stph, status, nw, lat);
  endtask

  task automatic ignored_req(input logic [2:0] len);
    clear_obs();
    req = 1'b1; req_rw = 1'b1; req_addr = 32'h1234_5678; req_len = len; req_be = 4'h0;
    step();
    req = 1'b0;
    repeat (4) step();
    check("bad_len_busy", {31'd0, busy}, 32'd0);
    check("bad_len_addr", addr_cnt, 0);
    $display("[TB] txn ignored request len=%0d busy=%0d", len, busy);
  endtask

  task automatic reset_mid();
    plan_dev = 1'b1; plan_stop = -1; plan_stop_data = 1'b0;
    for (int i = 0; i < 4; i++) plan_wait[i] = 0;
    cur_rw = 1'b1; cur_len = 4; exp_be = 4'h0;
    clear_obs();
    req = 1'b1; req_rw = 1'b1; req_addr = 32'h0000_2000; req_len = 3'd4; req_be = 4'h0;
    step();
    req = 1'b0;
    repeat (3) step();
    rest = 1'b1;
    step();
    check("rst_frame", {31'd0, frame}, 32'd1);
    check("rst_irdy", {31'd0, irdy}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cbe", {28'd0, cbe}, 32'hF);
    rest = 1'b0;
    repeat (4) step();
    check("rst_no_done", done_cnt, 0);
    check("rst_status", {30'd0, status}, 32'd0);
    $display("[TB] txn reset mid-burst frame=%0d irdy=%0d busy=%0d", frame, irdy, busy);
  endtask

  initial begin
    bit rw, dev, stdat;
    int len, stph;
    rest = 1'b1; req = 1'b0; req_rw = 1'b0; req_addr = 32'd0; req_len = 3'd0; req_be = 4'hF;
    ld_en = 1'b0; ld_idx = 2'd0; ld_data = 32'd0;
    repeat (3) step();
    check("reset_frame", {31'd0, frame}, 32'd1);
    check("reset_irdy", {31'd0, irdy}, 32'd1);
    check("reset_cbe", {28'd0, cbe}, 32'hF);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("reset_status", {30'd0, status}, 32'd0);
    rest = 1'b0;
    step();

    for (int i = 0; i < 4; i++) load(2'(i), 32'hA0A0_0000 + 32'(i));
    run_txn(1'b1, 32'hFFFF_0000, 4, 4'h0, 1'b1, -1, 1'b0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 32'hFFFF_0004, 2, 4'h0, 1'b1, -1, 1'b0, 2, 1'b0, 1'b0);
    run_txn(1'b0, 32'h0000_1000, 2, 4'h0, 1'b0, -1, 1'b0, 0, 1'b0, 1'b0);
    run_txn(1'b1, 32'h0000_3000, 4, 4'h3, 1'b1, 1, 1'b1, 0, 1'b0, 1'b0);
    reset_mid();
    ignored_req(3'd0);
    ignored_req(3'd5);
    run_txn(1'b1, 32'h0000_4003, 3, 4'h0, 1'b1, -1, 1'b0, 0, 1'b1, 1'b1);

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 2) == 0) load(2'($urandom_range(0, 3)), $urandom);
      rw = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 4);
      dev = ($urandom_range(0, 7) != 0);
      stph = (dev && $urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      stdat = 1'($urandom_range(0, 1));
      run_txn(rw, $urandom, len, 4'($urandom_range(0, 15)), dev, stph, stdat,
              $urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
